fp_neuron_accum: RTL and testbench
==================================

FP_NEURON_ACCUM -- requirements
Module: fp_neuron_accum

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the per-neuron term count.
REQ-002 SHALL have parameter RELU_EN, default 1; 1 applies ReLU to the final result.
REQ-003 SHALL have port clk_x70  input  1  sole clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst_n_x70  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start_x70  input  1  one-cycle pulse that begins one neuron.
REQ-006 SHALL have port bias_x70  input  32  IEEE-754 single bias, sampled with start_x70.
REQ-007 SHALL have port num_terms_x70  input  CNT_W  terms to accumulate, sampled with start_x70; 0 is legal.
REQ-008 SHALL have port term_x70  input  32  incoming product term (float).
REQ-009 SHALL have port term_valid_x70  input  1  term_x70 valid.
REQ-010 SHALL have port term_ready_x70  output  1  block accepts a term this cycle.
REQ-011 SHALL have port add_a_x70  output  32  operand A to the external registered fp_adder.
REQ-012 SHALL have port add_b_x70  output  32  operand B to the external fp_adder.
REQ-013 SHALL have port add_sum_x70  input  32  fp_adder registered sum (latency one rising edge).
REQ-014 SHALL have port busy_x70  output  1  high in every state except IDLE.
REQ-015 SHALL have port result_x70  output  32  final neuron value.
REQ-016 SHALL have port result_valid_x70  output  1  result_x70 valid.
REQ-017 SHALL have port result_ready_x70  input  1  consumer accepts result.

Function
REQ-018 SHALL implement the FSM states IDLE, ACCEPT, ADD, CAPTURE and OUT, with a 32-bit accumulator acc and a CNT_W-bit remaining counter rem.
REQ-019 In IDLE, on start_x70, the block SHALL load acc<=bias_x70 and rem<=num_terms_x70, then go to OUT if num_terms_x70==0 and to ACCEPT otherwise.
REQ-020 The block SHALL ignore start_x70 in every state except IDLE.
REQ-021 term_ready_x70 SHALL be 1 only in ACCEPT, and a term SHALL transfer only on a cycle with term_valid_x70 && term_ready_x70.
REQ-022 On transfer, if term[30:23]==0 (zero or denormal, flushed), the block SHALL leave acc unchanged, decrement rem, and go to OUT if rem was 1 and stay in ACCEPT otherwise.
REQ-023 On transfer, if acc[30:23]==0, the block SHALL set acc<=term, decrement rem, and branch as in REQ-022.
REQ-024 On transfer, if term[30:0]==acc[30:0] and the sign bits differ (exact cancellation), the block SHALL set acc<=32'h0, decrement rem, and branch as in REQ-022.
REQ-025 On any other transfer, the block SHALL register add_a_x70<=acc and add_b_x70<=term and go to ADD.
REQ-026 ADD SHALL last one cycle with the operands held stable and SHALL then go to CAPTURE.
REQ-027 In CAPTURE, the block SHALL set acc<=add_sum_x70, hold the operands, decrement rem, and go to OUT if rem was 1 and to ACCEPT otherwise.
REQ-028 A non-bypassed term SHALL occupy 3 cycles (ACCEPT, ADD, CAPTURE), and a bypassed term SHALL occupy 1 cycle.
REQ-029 In OUT, result_valid_x70 SHALL be 1 and result_x70 SHALL be 32'h0 when RELU_EN==1 and acc[31]==1, and acc otherwise.
REQ-030 result_x70 and result_valid_x70 SHALL stay stable while result_ready_x70 is 0.
REQ-031 When result_ready_x70 is 1 in OUT, the block SHALL go to IDLE on the next edge and deassert result_valid_x70.
REQ-032 Latency from start to result_valid SHALL be 1 cycle with num_terms=0 and, with terms always valid, 1+3k+b cycles, where k is the number of adds and b the number of bypassed terms.
REQ-033 rem SHALL never wrap, because OUT is entered on the last decrement.

Reset
REQ-034 When rst_n_x70==0 at a rising edge, the block SHALL enter IDLE and clear acc, rem, add_a_x70, add_b_x70, result_x70, result_valid_x70, term_ready_x70 and busy_x70 to 0.
REQ-035 Reset SHALL take priority over all other inputs in any state, and the in-flight neuron SHALL be discarded with no result produced.

Verification (bench connects the team fp_adder to add_*; RELU_EN=1 unless stated)
REQ-036 bias 3F800000, num_terms 2, terms 40000000 then 3F000000 -> result_x70=40600000 (3.5), result_valid_x70 asserted 7 cycles after start.
REQ-037 num_terms 0, bias BF800000 -> result 00000000; with RELU_EN=0 -> result BF800000, 1 cycle after start.
REQ-038 bias 3F800000, terms 00000000 then 40000000 -> result 40400000; add_b_x70 never equals 00000000 during ADD.
REQ-039 bias 40000000, term C0000000 -> result 00000000 with no ADD state entered; bias 00000000, term 3F800000 -> result 3F800000.
REQ-040 result_ready_x70 held 0 for 5 cycles in OUT, with start pulsed and term_valid high -> result stable, term_ready_x70 0, start ignored; result_ready 1 -> IDLE next cycle.
REQ-041 rst_n_x70=0 for one cycle while in ADD -> next cycle busy_x70=0, all outputs 0; new start then completes normally.

Source files
------------

// File: rtl/fp_neuron_accum.sv
// Floating-point neuron accumulator: bias plus a stream of product terms, summed through
// an external registered fp_adder, with optional ReLU on the final value.
module fp_neuron_accum #(
    parameter int CNT_W   = 8,
    parameter int RELU_EN = 1
) (
    input  logic             clk_x70,
    input  logic             rst_n_x70,
    input  logic             start_x70,
    input  logic [31:0]      bias_x70,
    input  logic [CNT_W-1:0] num_terms_x70,
    input  logic [31:0]      term_x70,
    input  logic             term_valid_x70,
    output logic             term_ready_x70,
    output logic [31:0]      add_a_x70,
    output logic [31:0]      add_b_x70,
    input  logic [31:0]      add_sum_x70,
    output logic             busy_x70,
    output logic [31:0]      result_x70,
    output logic             result_valid_x70,
    input  logic             result_ready_x70
);

    typedef enum logic [2:0] {IDLE, ACCEPT, ADD, CAPTURE, OUT} state_t;

    state_t           state, state_nxt;
    logic [31:0]      acc, acc_nxt;
    logic [31:0]      add_a, add_a_nxt;
    logic [31:0]      add_b, add_b_nxt;
    logic [CNT_W-1:0] rem, rem_nxt;

    logic xfer, term_flush, acc_zero, cancel, last;

    assign xfer       = term_valid_x70 && (state == ACCEPT);
    assign term_flush = (term_x70[30:23] == 8'h00);
    assign acc_zero   = (acc[30:23] == 8'h00);
    assign cancel     = (term_x70[30:0] == acc[30:0]) && (term_x70[31] != acc[31]);
    assign last       = (rem == CNT_W'(1));

    always_ff @(posedge clk_x70) begin
        if (!rst_n_x70) begin
            state <= IDLE;
            acc   <= 32'h0;
            rem   <= '0;
            add_a <= 32'h0;
            add_b <= 32'h0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            rem   <= rem_nxt;
            add_a <= add_a_nxt;
            add_b <= add_b_nxt;
        end
    end

    // Terms that cannot change acc, or whose sum is trivially known, skip the adder.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        rem_nxt   = rem;
        add_a_nxt = add_a;
        add_b_nxt = add_b;
        case (state)
            IDLE: begin
                if (start_x70) begin
                    acc_nxt   = bias_x70;
                    rem_nxt   = num_terms_x70;
                    state_nxt = (num_terms_x70 == '0) ? OUT : ACCEPT;
                end
            end
            ACCEPT: begin
                if (xfer) begin
                    if (term_flush || acc_zero || cancel) begin
                        if (term_flush)
                            acc_nxt = acc;
                        else if (acc_zero)
                            acc_nxt = term_x70;
                        else
                            acc_nxt = 32'h0;
                        rem_nxt   = rem - CNT_W'(1);
                        state_nxt = last ? OUT : ACCEPT;
                    end else begin
                        add_a_nxt = acc;
                        add_b_nxt = term_x70;
                        state_nxt = ADD;
                    end
                end
            end
            ADD: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                acc_nxt   = add_sum_x70;
                rem_nxt   = rem - CNT_W'(1);
                state_nxt = last ? OUT : ACCEPT;
            end
            OUT: begin
                if (result_ready_x70)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign add_a_x70        = add_a;
    assign add_b_x70        = add_b;
    assign term_ready_x70   = (state == ACCEPT);
    assign busy_x70         = (state != IDLE);
    assign result_valid_x70 = (state == OUT);
    assign result_x70       = (state != OUT)                ? 32'h0 :
                              ((RELU_EN != 0) && acc[31])   ? 32'h0 : acc;

endmodule

// File: tb/tb_fp_neuron_accum.sv
// Randomized and directed checks of fp_neuron_accum against a real-arithmetic neuron model,
// with a behavioural registered adder on the add_* ports of two instances (ReLU on and off).
module tb_fp_neuron_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bias_in = 32'h0;
    logic [7:0]  num_terms = 8'h0;
    logic [31:0] term_in = 32'h0;
    logic        term_valid = 1'b0;
    logic        result_ready = 1'b0;

    logic        term_ready0, busy0, result_valid0;
    logic [31:0] add_a0, add_b0, add_sum0, result0;
    logic        term_ready1, busy1, result_valid1;
    logic [31:0] add_a1, add_b1, add_sum1, result1;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] stim_terms[$];

    always #5 clk = ~clk;

    fp_neuron_accum #(.CNT_W(8), .RELU_EN(1)) dut0 (
        .clk_x70(clk), .rst_n_x70(rst_n), .start_x70(start), .bias_x70(bias_in),
        .num_terms_x70(num_terms), .term_x70(term_in), .term_valid_x70(term_valid),
        .term_ready_x70(term_ready0), .add_a_x70(add_a0), .add_b_x70(add_b0),
        .add_sum_x70(add_sum0), .busy_x70(busy0), .result_x70(result0),
        .result_valid_x70(result_valid0), .result_ready_x70(result_ready)
    );

    fp_neuron_accum #(.CNT_W(8), .RELU_EN(0)) dut1 (
        .clk_x70(clk), .rst_n_x70(rst_n), .start_x70(start), .bias_x70(bias_in),
        .num_terms_x70(num_terms), .term_x70(term_in), .term_valid_x70(term_valid),
        .term_ready_x70(term_ready1), .add_a_x70(add_a1), .add_b_x70(add_b1),
        .add_sum_x70(add_sum1), .busy_x70(busy1), .result_x70(result1),
        .result_valid_x70(result_valid1), .result_ready_x70(result_ready)
    );

    // Single float <-> real; stimulus stays on a quarter grid so every sum is exact.
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'h00) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'h0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    always @(posedge clk) begin
        add_sum0 <= r2f(f2r(add_a0) + f2r(add_b0));
        add_sum1 <= r2f(f2r(add_a1) + f2r(add_b1));
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_val();
        real v;
        v = real'($urandom_range(1, 64)) / 4.0;
        if ($urandom_range(0, 1) == 1) v = -v;
        return r2f(v);
    endfunction

    task automatic applyStimulus(input logic [31:0] bias, input int hold,
                                 output logic [31:0] res0, output logic [31:0] res1,
                                 output int lat);
        real acc_m, t;
        int n, k, b, idx, cyc, add_cyc;
        bit done, xfer;
        logic [31:0] exp_relu, exp_raw;
        n = stim_terms.size();
        acc_m = f2r(bias);
        k = 0;
        b = 0;
        foreach (stim_terms[i]) begin
            t = f2r(stim_terms[i]);
            if (t == 0.0) b++;
            else if (acc_m == 0.0) begin acc_m = t; b++; end
            else if (acc_m + t == 0.0) begin acc_m = 0.0; b++; end
            else begin acc_m = acc_m + t; k++; end
        end
        exp_raw  = r2f(acc_m);
        exp_relu = (acc_m < 0.0) ? 32'h0 : exp_raw;

        @(negedge clk);
        start = 1'b1;
        bias_in = bias;
        num_terms = 8'(n);
        idx = 0;
        cyc = 0;
        add_cyc = 0;
        done = 1'b0;
        while (!done && cyc < 500) begin
            term_valid = (idx < n);
            term_in = (idx < n) ? stim_terms[idx] : 32'h0;
            xfer = term_valid && term_ready0;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0;
            if (xfer) idx++;
            if (busy0 && !term_ready0 && !result_valid0) begin
                add_cyc++;
                checkOutput("add_b_nonzero", {31'h0, add_b0[30:23] != 8'h00}, 32'h1);
            end
            if (result_valid0) done = 1'b1;
        end
        term_valid = 1'b0;
        checkOutput("result_arrives", {31'h0, done}, 32'h1);
        checkOutput("latency", 32'(cyc), 32'(1 + 3 * k + b));
        checkOutput("adder_cycles", 32'(add_cyc), 32'(2 * k));
        checkOutput("result_relu", result0, exp_relu);
        checkOutput("result_raw", result1, exp_raw);
        checkOutput("valid_raw", {31'h0, result_valid1}, 32'h1);
        res0 = result0;
        res1 = result1;
        lat = cyc;

        for (int h = 0; h < hold; h++) begin
            start = (h == 0);
            term_valid = 1'b1;
            term_in = 32'h3F800000;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            checkOutput("hold_result", result0, exp_relu);
            checkOutput("hold_valid", {31'h0, result_valid0}, 32'h1);
            checkOutput("hold_no_ready", {31'h0, term_ready0}, 32'h0);
        end
        term_valid = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        checkOutput("idle_busy", {31'h0, busy0}, 32'h0);
        checkOutput("idle_valid", {31'h0, result_valid0}, 32'h0);
        checkOutput("idle_busy_raw", {31'h0, busy1}, 32'h0);
    endtask

    initial begin
        logic [31:0] r0, r1, bias;
        int lat, n;
        real run;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", {31'h0, busy0}, 32'h0);
        checkOutput("rst_valid", {31'h0, result_valid0}, 32'h0);
        checkOutput("rst_ready", {31'h0, term_ready0}, 32'h0);
        checkOutput("rst_result", result0, 32'h0);
        checkOutput("rst_add_a", add_a0, 32'h0);
        checkOutput("rst_add_b", add_b0, 32'h0);
        rst_n = 1'b1;

        stim_terms = '{32'h40000000, 32'h3F000000};
        applyStimulus(32'h3F800000, 0, r0, r1, lat);
        checkOutput("two_adds_result", r0, 32'h40600000);
        checkOutput("two_adds_latency", 32'(lat), 32'd7);

        stim_terms = {};
        applyStimulus(32'hBF800000, 0, r0, r1, lat);
        checkOutput("empty_relu", r0, 32'h00000000);
        checkOutput("empty_raw", r1, 32'hBF800000);
        checkOutput("empty_latency", 32'(lat), 32'd1);

        stim_terms = '{32'h00000000, 32'h40000000};
        applyStimulus(32'h3F800000, 0, r0, r1, lat);
        checkOutput("zero_term_result", r0, 32'h40400000);

        stim_terms = '{32'hC0000000};
        applyStimulus(32'h40000000, 0, r0, r1, lat);
        checkOutput("cancel_result", r0, 32'h00000000);
        checkOutput("cancel_latency", 32'(lat), 32'd2);

        stim_terms = '{32'h3F800000};
        applyStimulus(32'h00000000, 0, r0, r1, lat);
        checkOutput("zero_acc_result", r0, 32'h3F800000);

        stim_terms = '{32'h3F800000};
        applyStimulus(32'h40000000, 5, r0, r1, lat);
        checkOutput("backpressure_result", r0, 32'h40400000);

        // Interrupt a neuron while the adder is in use.
        @(negedge clk);
        start = 1'b1;
        bias_in = 32'h3F800000;
        num_terms = 8'd1;
        term_valid = 1'b1;
        term_in = 32'h40000000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_add_busy", {31'h0, busy0}, 32'h1);
        checkOutput("mid_add_operand", add_b0, 32'h40000000);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        term_valid = 1'b0;
        checkOutput("abort_busy", {31'h0, busy0}, 32'h0);
        checkOutput("abort_valid", {31'h0, result_valid0}, 32'h0);
        checkOutput("abort_ready", {31'h0, term_ready0}, 32'h0);
        checkOutput("abort_result", result0, 32'h0);
        checkOutput("abort_add_a", add_a0, 32'h0);
        checkOutput("abort_add_b", add_b0, 32'h0);
        checkOutput("abort_busy_raw", {31'h0, busy1 | term_ready1}, 32'h0);
        stim_terms = '{32'h40000000};
        applyStimulus(32'h3F800000, 0, r0, r1, lat);
        checkOutput("after_abort_result", r0, 32'h40400000);

        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 8);
            case ($urandom_range(0, 3))
                0:       bias = 32'h0;
                default: bias = rand_val();
            endcase
            run = f2r(bias);
            stim_terms = {};
            for (int i = 0; i < n; i++) begin
                logic [31:0] t;
                case ($urandom_range(0, 9))
                    0:       t = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h0;
                    1:       t = {9'h0, 23'($urandom_range(1, 32'h7FFFFF))};
                    2:       t = (run != 0.0) ? r2f(-run) : rand_val();
                    default: t = rand_val();
                endcase
                stim_terms.push_back(t);
                if (f2r(t) != 0.0) run = (run == 0.0) ? f2r(t) : run + f2r(t);
            end
            applyStimulus(bias, $urandom_range(0, 3), r0, r1, lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
